// File: rtl/note_recorder.sv
// -----------------------------------------------------------------------------
// note_recorder
//   Records live key notes into an internal buffer, one entry per tempo beat,
//   and plays the stored take back as a note-code stream at the beat rate.
//
//   Optional feature macro: PLAY_LOOP_EN
//     defined   : playback wraps to entry 0 at the end of the take and keeps going
//     undefined : the end-of-take beat returns the recorder to IDLE
//
// Ports
//   clk_5MHz    system clock
//   rst         synchronous active-high reset
//   beat_tick   one-cycle pulse per beat
//   note_in     live note code (0 = rest / no key)
//   rec_start   pulse: start a new recording
//   play_start  pulse: play back the stored take
//   stop        pulse: abort record/playback
//   note_out    played-back note code
//   note_valid  note_out carries a played-back note
//   recording   high while recording
//   playing     high while playing
//   full        last recording filled the buffer
//   rec_len     number of stored beats, 0..DEPTH
// -----------------------------------------------------------------------------
module note_recorder #(
  parameter int NOTE_W = 5,
  parameter int ADDR_W = 6,
  parameter int DEPTH  = 64
) (
  input  logic              clk_5MHz,
  input  logic              rst,
  input  logic              beat_tick,
  input  logic [NOTE_W-1:0] note_in,
  input  logic              rec_start,
  input  logic              play_start,
  input  logic              stop,
  output logic [NOTE_W-1:0] note_out,
  output logic              note_valid,
  output logic              recording,
  output logic              playing,
  output logic              full,
  output logic [ADDR_W:0]   rec_len
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REC  = 2'd1,
    PLAY = 2'd2
  } state_t;

  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0] LAST_C  = DEPTH_C - 1'b1;
  localparam logic [ADDR_W:0] ONE_C   = (ADDR_W + 1)'(1);

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d;
  // One bit wider than the address so it can be compared against rec_len,
  // which reaches DEPTH on a full take.
  logic [ADDR_W:0]     rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]     rec_len_q, rec_len_d;
  logic                full_q, full_d;
  logic                recording_q, playing_q, note_valid_q;
  logic [NOTE_W-1:0]   note_out_q;

  logic                wr_en;
  logic                rd_en;
  logic [ADDR_W-1:0]   rd_addr;

  logic [NOTE_W-1:0]   mem [DEPTH];

  // ---------------------------------------------------------------------------
  // Next-state logic. Command priority: stop > rec_start > play_start.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    rec_len_d = rec_len_q;
    full_d    = full_q;
    wr_en     = 1'b0;
    rd_en     = 1'b0;
    rd_addr   = rd_ptr_q[ADDR_W-1:0];

    case (state_q)
      IDLE: begin
        if (stop) begin
          state_d = IDLE;
        end else if (rec_start) begin
          state_d   = REC;
          wr_ptr_d  = '0;
          rec_len_d = '0;
          full_d    = 1'b0;
        end else if (play_start && (rec_len_q != '0)) begin
          state_d  = PLAY;
          rd_ptr_d = '0;
        end
      end

      REC: begin
        if (stop) begin
          state_d = IDLE;
        end else if (rec_start) begin
          // Restart the take; the coincident beat is not captured.
          wr_ptr_d  = '0;
          rec_len_d = '0;
          full_d    = 1'b0;
        end else if (beat_tick && (rec_len_q < DEPTH_C)) begin
          wr_en     = 1'b1;
          wr_ptr_d  = wr_ptr_q + 1'b1;
          rec_len_d = rec_len_q + 1'b1;
          // Last free entry: stop recording instead of wrapping.
          if (rec_len_q == LAST_C) begin
            full_d  = 1'b1;
            state_d = IDLE;
          end
        end
      end

      PLAY: begin
        if (stop) begin
          state_d = IDLE;
        end else if (rec_start) begin
          state_d   = REC;
          wr_ptr_d  = '0;
          rec_len_d = '0;
          full_d    = 1'b0;
        end else if (beat_tick) begin
          if (rd_ptr_q == rec_len_q) begin
            // Every stored entry has been presented: end of take.
`ifdef PLAY_LOOP_EN
            rd_en    = 1'b1;
            rd_addr  = '0;
            rd_ptr_d = ONE_C;
`else
            state_d  = IDLE;
`endif
          end else begin
            rd_en    = 1'b1;
            rd_ptr_d = rd_ptr_q + 1'b1;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Control registers and registered status outputs.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_5MHz) begin
    if (rst) begin
      state_q      <= IDLE;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      rec_len_q    <= '0;
      full_q       <= 1'b0;
      recording_q  <= 1'b0;
      playing_q    <= 1'b0;
      note_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      rec_len_q    <= rec_len_d;
      full_q       <= full_d;
      recording_q  <= (state_d == REC);
      playing_q    <= (state_d == PLAY);
      // Valid from the first presented beat until PLAY is left.
      note_valid_q <= (state_d == PLAY) && (rd_en || note_valid_q);
    end
  end

  // Buffer write port; contents survive reset.
  always_ff @(posedge clk_5MHz) begin
    if (wr_en && !rst) begin
      mem[wr_ptr_q] <= note_in;
    end
  end

  // Registered read port doubles as the note_out register; its synchronous
  // clear forces silence whenever PLAY is not the next state.
  always_ff @(posedge clk_5MHz) begin
    if (rst || (state_d != PLAY)) begin
      note_out_q <= '0;
    end else if (rd_en) begin
      note_out_q <= mem[rd_addr];
    end
  end

  assign note_out   = note_out_q;
  assign note_valid = note_valid_q;
  assign recording  = recording_q;
  assign playing    = playing_q;
  assign full       = full_q;
  assign rec_len    = rec_len_q;

endmodule

// File: tb/tb_note_recorder.sv
// -----------------------------------------------------------------------------
// tb_note_recorder
//   Self-checking bench for note_recorder: directed scenarios followed by a
//   randomized command/beat stream, all compared every cycle against a
//   behavioural model built on a plain note array and a take length.
//   Honours PLAY_LOOP_EN the same way the design does.
// -----------------------------------------------------------------------------
module tb_note_recorder;

  localparam int M_IDLE = 0;
  localparam int M_REC  = 1;
  localparam int M_PLAY = 2;

  logic       clk_5MHz = 1'b0;
  logic       rst = 1'b0;
  logic       beat_tick = 1'b0;
  logic [4:0] note_in = '0;
  logic       rec_start = 1'b0;
  logic       play_start = 1'b0;
  logic       stop = 1'b0;
  logic [4:0] note_out;
  logic       note_valid;
  logic       recording;
  logic       playing;
  logic       full;
  logic [6:0] rec_len;

  int checks = 0;
  int failures = 0;

  // Behavioural model
  int m_mode = M_IDLE;
  int m_len = 0;
  int m_full = 0;
  int m_pidx = 0;
  int m_out = 0;
  int m_valid = 0;
  int m_buf [64];

  note_recorder #(.NOTE_W(5), .ADDR_W(6), .DEPTH(64)) dut (
    .clk_5MHz  (clk_5MHz),
    .rst       (rst),
    .beat_tick (beat_tick),
    .note_in   (note_in),
    .rec_start (rec_start),
    .play_start(play_start),
    .stop      (stop),
    .note_out  (note_out),
    .note_valid(note_valid),
    .recording (recording),
    .playing   (playing),
    .full      (full),
    .rec_len   (rec_len)
  );

  always #5 clk_5MHz = ~clk_5MHz;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d t=%0t", tag, obs, exp, $time);
    end
  endtask

  // One clock edge of the recorder as described by its command rules.
  task automatic model_edge(input bit r, input bit t, input int n,
                            input bit rs, input bit ps, input bit sp);
    if (r) begin
      m_mode = M_IDLE; m_len = 0; m_full = 0; m_pidx = 0; m_out = 0; m_valid = 0;
      return;
    end
    case (m_mode)
      M_IDLE: begin
        if (sp) begin
        end else if (rs) begin
          m_mode = M_REC; m_len = 0; m_full = 0;
        end else if (ps && m_len > 0) begin
          m_mode = M_PLAY; m_pidx = 0;
        end
      end
      M_REC: begin
        if (sp) m_mode = M_IDLE;
        else if (rs) begin
          m_len = 0; m_full = 0;
        end else if (t) begin
          m_buf[m_len] = n;
          m_len++;
          if (m_len == 64) begin
            m_full = 1; m_mode = M_IDLE;
          end
        end
      end
      default: begin
        if (sp) m_mode = M_IDLE;
        else if (rs) begin
          m_mode = M_REC; m_len = 0; m_full = 0;
        end else if (t) begin
          if (m_pidx < m_len) begin
            m_out = m_buf[m_pidx]; m_valid = 1; m_pidx++;
          end else begin
`ifdef PLAY_LOOP_EN
            m_out = m_buf[0]; m_valid = 1; m_pidx = 1;
`else
            m_mode = M_IDLE;
`endif
          end
        end
      end
    endcase
    if (m_mode != M_PLAY) begin
      m_out = 0; m_valid = 0;
    end
  endtask

  task automatic compare_all();
    check("note_out",   note_out,   m_out);
    check("note_valid", note_valid, m_valid);
    check("recording",  recording,  m_mode == M_REC);
    check("playing",    playing,    m_mode == M_PLAY);
    check("full",       full,       m_full);
    check("rec_len",    rec_len,    m_len);
  endtask

  // Drive one cycle of inputs, advance DUT and model, then compare.
  task automatic step(input bit r, input bit t, input int n,
                      input bit rs, input bit ps, input bit sp);
    logic [4:0] nv;
    nv = n[4:0];
    rst = r; beat_tick = t; note_in = nv;
    rec_start = rs; play_start = ps; stop = sp;
    @(posedge clk_5MHz);
    model_edge(r, t, int'(nv), rs, ps, sp);
    #1;
    rst = 0; beat_tick = 0; rec_start = 0; play_start = 0; stop = 0;
    note_in = 5'($urandom_range(0, 31));
    compare_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, int'($urandom_range(0, 31)), 0, 0, 0);
  endtask

  task automatic tick(input int n, input int gap);
    step(0, 1, n, 0, 0, 0);
    idle(gap);
  endtask

  int basic_notes [4] = '{3, 5, 0, 7};
  int tempo_rec [$];
  int tempo_play [$];

  initial begin
    #1;
    // 1. Reset values and ignored play_start on an empty buffer
    step(1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    check("reset_rec_len", rec_len, 0);
    check("reset_note_out", note_out, 0);
    step(0, 0, 0, 0, 1, 0);
    idle(2);
    check("empty_play_ignored", playing, 0);
    $display("txn reset checks=%0d failures=%0d", checks, failures);

    // 2. Basic record and playback
    step(0, 0, 0, 1, 0, 0);
    idle(2);
    foreach (basic_notes[i]) tick(basic_notes[i], 3);
    step(0, 0, 0, 0, 0, 1);
    check("basic_rec_len", rec_len, 4);
    check("basic_full", full, 0);
    step(0, 0, 0, 0, 1, 0);
    idle(2);
    foreach (basic_notes[i]) begin
      step(0, 1, 0, 0, 0, 0);
      check("basic_play_note", note_out, basic_notes[i]);
      check("basic_play_valid", note_valid, 1);
      idle(3);
    end
    step(0, 1, 0, 0, 0, 0);
`ifdef PLAY_LOOP_EN
    check("end_of_take_note", note_out, 3);
    step(0, 0, 0, 0, 0, 1);
`else
    check("end_of_take_note", note_out, 0);
    check("end_of_take_playing", playing, 0);
`endif
    idle(2);
    $display("txn basic checks=%0d failures=%0d", checks, failures);

    // 3. Full buffer
    step(0, 0, 0, 1, 0, 0);
    for (int i = 0; i < 64; i++) tick(i % 32, 1);
    check("full_flag", full, 1);
    check("full_rec_len", rec_len, 64);
    check("full_recording", recording, 0);
    tick(9, 2);
    check("full_no_extra_write", rec_len, 64);
    step(0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 66; i++) tick(0, 1);
    step(0, 0, 0, 0, 0, 1);
    $display("txn full checks=%0d failures=%0d", checks, failures);

    // 4. Coincident commands
    step(0, 0, 0, 1, 0, 1);
    check("stop_beats_rec", recording, 0);
    step(0, 1, 12, 1, 0, 0);
    check("rec_start_tick_not_stored", rec_len, 0);
    idle(2);
    check("rec_start_tick_len_hold", rec_len, 0);
    tick(4, 1);
    check("first_tick_stored", rec_len, 1);
    tick(6, 1);
    tick(8, 1);
    step(0, 0, 0, 0, 0, 1);
    $display("txn coincident checks=%0d failures=%0d", checks, failures);

    // 5. Mid-operation reset and record restart
    step(0, 0, 0, 0, 1, 0);
    tick(0, 2);
    step(1, 1, 0, 0, 0, 0);
    check("rst_play_note_out", note_out, 0);
    check("rst_play_rec_len", rec_len, 0);
    step(0, 0, 0, 1, 0, 0);
    tick(17, 1); tick(18, 1); tick(19, 1);
    step(0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1, 0);
    tick(0, 2);
    step(0, 0, 0, 1, 0, 0);
    check("restart_recording", recording, 1);
    check("restart_playing", playing, 0);
    check("restart_valid", note_valid, 0);
    step(0, 0, 0, 0, 0, 1);
    $display("txn midop checks=%0d failures=%0d", checks, failures);

    // 6. Tempo independence: record at 4-cycle spacing, play at 9-cycle spacing
    step(0, 0, 0, 1, 0, 0);
    for (int i = 0; i < 8; i++) begin
      tempo_rec.push_back(int'($urandom_range(0, 31)));
      tick(tempo_rec[i], 3);
    end
    step(0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 8; i++) begin
      step(0, 1, 0, 0, 0, 0);
      tempo_play.push_back(int'(note_out));
      for (int k = 0; k < 8; k++) begin
        step(0, 0, 0, 0, 0, 0);
        check("tempo_hold", note_out, tempo_play[i]);
      end
    end
    for (int i = 0; i < 8; i++) check("tempo_seq", tempo_play[i], tempo_rec[i]);
    step(0, 0, 0, 0, 0, 1);
    $display("txn tempo checks=%0d failures=%0d", checks, failures);

    // Randomized command/beat stream
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 799) == 0,
           $urandom_range(0, 2) == 0,
           int'($urandom_range(0, 31)),
           $urandom_range(0, 59) == 0,
           $urandom_range(0, 14) == 0,
           $urandom_range(0, 79) == 0);
    end
    $display("txn random checks=%0d failures=%0d", checks, failures);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
